alu_seq: RTL and testbench

//  Parametrised, handshaked successor to the single-cycle datapath ALU.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_if.sv | 34 +++
 rtl/alu_seq_core.sv | 59 +++++
 rtl/alu_seq.sv | 194 +++++++++++++++++++
 tb/tb_alu_seq.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared definitions for the sequential ALU: operation encodings, FSM state
//   encoding and a helper that identifies the multi-cycle operations.
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'b0000,
        OP_SUB  = 4'b0001,
        OP_AND  = 4'b0010,
        OP_OR   = 4'b0011,
        OP_XOR  = 4'b0100,
        OP_SLT  = 4'b0101,
        OP_MUL  = 4'b1000,
        OP_DIVU = 4'b1001,
        OP_REMU = 4'b1010
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // mul/divu/remu iterate one bit per cycle; everything else finishes at accept.
    function automatic logic is_multi(input logic [3:0] f);
        return (f == OP_MUL) || (f == OP_DIVU) || (f == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
//   Operand/result handshake bundle for alu_seq.
//   master : operand fetch / writeback side (drives operands, consumes result)
//   slave  : the ALU itself
//   Request : in_valid/in_ready, a, b, f
//   Response: out_valid/out_ready, result, zero, overflow, carry, negative
// ---------------------------------------------------------------------------
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       f;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             carry;
    logic             negative;

    modport master (
        output in_valid, a, b, f, out_ready,
        input  in_ready, out_valid, result, zero, overflow, carry, negative
    );

    modport slave (
        input  in_valid, a, b, f, out_ready,
        output in_ready, out_valid, result, zero, overflow, carry, negative
    );
endinterface

// File: rtl/alu_seq_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational single-cycle ALU: add, sub, and, or, xor, slt.
//   Ports:
//     a, b     in   WIDTH  operands
//     f        in   4      op code (alu_op_e encoding)
//     result   out  WIDTH  op result, 0 for codes this core does not handle
//     sum      out  WIDTH  raw adder output, a + (f[0] ? ~b : b) + f[0]
//     carry    out  1      adder carry-out (add/sub only, else 0)
//     overflow out  1      signed overflow (add/sub only, else 0)
//   The sequencer reuses sum/carry with f = OP_SUB as the divider's trial
//   subtract, so the adder is built unconditionally on f[0].
// ---------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       f,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_ext;
    logic             add_ov;
    logic             add_co;

    always_comb begin
        sub     = f[0];
        b_eff   = sub ? ~b : b;
        sum_ext = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(sub);
        sum     = sum_ext[WIDTH-1:0];
        add_co  = sum_ext[WIDTH];
        // Operands of equal sign producing a sum of the other sign.
        add_ov  = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (f)
            OP_ADD, OP_SUB: begin
                result   = sum;
                carry    = add_co;
                overflow = add_ov;
            end
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            // Signed less-than: the true sign of a-b is the sum sign corrected by overflow.
            OP_SLT: result = {{(WIDTH - 1){1'b0}}, add_ov ^ sum[WIDTH-1]};
            default: result = '0;
        endcase
    end
endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//   Handshaked ALU with registered result and flags. Single-cycle ops
//   complete at accept; mul (shift-add), divu/remu (restoring) take one bit
//   per cycle for WIDTH cycles. One operation in flight at a time.
//   Ports:
//     clk    in  1   clock, rising edge
//     reset  in  1   asynchronous active-high reset, clears all state
//     bus    slave   alu_seq_if: in_valid/in_ready, a, b, f,
//                    out_valid/out_ready, result, zero, overflow, carry, negative
// ---------------------------------------------------------------------------
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    alu_seq_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_e             state_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   result_q;
    logic               zero_q;
    logic               ov_q;
    logic               carry_q;
    logic               neg_q;

    alu_op_e            op_q;
    logic [WIDTH-1:0]   b_q;
    // Shared accumulator: mul -> {partial product, multiplier},
    // div -> {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   core_a;
    logic [WIDTH-1:0]   core_b;
    logic [3:0]         core_f;
    logic [WIDTH-1:0]   core_res;
    logic [WIDTH-1:0]   core_sum;
    logic               core_carry;
    logic               core_ov;

    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] mul_next;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] step_next;
    logic               div_ge;

    logic [WIDTH-1:0]   ld_res;
    logic               ld_ov;
    logic               ld_carry;
    logic               ld_zero;
    logic               ld_neg;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a        (core_a),
        .b        (core_b),
        .f        (core_f),
        .result   (core_res),
        .sum      (core_sum),
        .carry    (core_carry),
        .overflow (core_ov)
    );

    always_comb begin
        acc_hi  = acc_q[2*WIDTH-1:WIDTH];
        acc_lo  = acc_q[WIDTH-1:0];
        // Remainder shifted left with the next dividend bit; the bit shifted out
        // of the top is kept separately in acc_hi[WIDTH-1].
        shifted = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};

        // While running, the core adder serves as the divider's trial subtract.
        core_a = (state_q == S_RUN) ? shifted : bus.a;
        core_b = (state_q == S_RUN) ? b_q     : bus.b;
        core_f = (state_q == S_RUN) ? OP_SUB  : bus.f;

        mul_add  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : {(WIDTH + 1){1'b0}});
        mul_next = {mul_add, acc_lo[WIDTH-1:1]};

        // Trial succeeds when the shifted remainder overflowed WIDTH bits (it then
        // certainly exceeds b) or when the subtract produced no borrow.
        div_ge   = acc_hi[WIDTH-1] | core_carry;
        div_next = {(div_ge ? core_sum : shifted), acc_lo[WIDTH-2:0], div_ge};

        step_next = (op_q == OP_MUL) ? mul_next : div_next;

        ld_res   = core_res;
        ld_ov    = core_ov;
        ld_carry = core_carry;
        if (state_q == S_RUN) begin
            ld_carry = 1'b0;
            case (op_q)
                OP_MUL: begin
                    ld_res = step_next[WIDTH-1:0];
                    ld_ov  = |step_next[2*WIDTH-1:WIDTH];
                end
                OP_DIVU: begin
                    ld_res = step_next[WIDTH-1:0];
                    ld_ov  = (b_q == '0);
                end
                OP_REMU: begin
                    ld_res = step_next[2*WIDTH-1:WIDTH];
                    ld_ov  = (b_q == '0);
                end
                default: begin
                    ld_res = '0;
                    ld_ov  = 1'b0;
                end
            endcase
        end
        ld_zero = (ld_res == '0);
        ld_neg  = ld_res[WIDTH-1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ov_q        <= 1'b0;
            carry_q     <= 1'b0;
            neg_q       <= 1'b0;
            op_q        <= OP_ADD;
            b_q         <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        op_q       <= alu_op_e'(bus.f);
                        b_q        <= bus.b;
                        acc_q      <= {{WIDTH{1'b0}}, bus.a};
                        in_ready_q <= 1'b0;
                        if (is_multi(bus.f)) begin
                            state_q <= S_RUN;
                            cnt_q   <= CNT_W'(WIDTH);
                        end else begin
                            state_q     <= S_DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= ld_res;
                            zero_q      <= ld_zero;
                            ov_q        <= ld_ov;
                            carry_q     <= ld_carry;
                            neg_q       <= ld_neg;
                        end
                    end
                end
                S_RUN: begin
                    acc_q <= step_next;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q     <= S_DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= ld_res;
                        zero_q      <= ld_zero;
                        ov_q        <= ld_ov;
                        carry_q     <= ld_carry;
                        neg_q       <= ld_neg;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = ov_q;
    assign bus.carry     = carry_q;
    assign bus.negative  = neg_q;
endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
//   Bench for alu_seq at WIDTH=32 and WIDTH=8 (two instances sharing clock
//   and reset). Directed vector table, reset and backpressure sequences, then
//   random operations compared with an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq;
    import alu_pkg::*;

    logic clk;
    logic reset;

    int ntests = 0;
    int nfail  = 0;

    alu_seq_if #(.WIDTH(32)) if32 ();
    alu_seq_if #(.WIDTH(8))  if8 ();

    alu_seq #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
    alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] res;
        logic        ov;
        logic        c;
        int          lat;
    } exp_t;

    typedef struct {
        bit          w8;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  f;
        logic [31:0] res;
        logic        ov;
        logic        c;
        logic        z;
        logic        n;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on WIDTH-bit values.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] f);
        exp_t e;
        longint unsigned m, ua, ub, p;
        longint sa, sb, r, lo, hi;
        m  = (longint'(1) << w) - 1;
        ua = a & m;
        ub = b & m;
        sa = (ua >= (longint'(1) << (w - 1))) ? longint'(ua) - (longint'(1) << w) : longint'(ua);
        sb = (ub >= (longint'(1) << (w - 1))) ? longint'(ub) - (longint'(1) << w) : longint'(ub);
        lo = -(longint'(1) << (w - 1));
        hi = (longint'(1) << (w - 1)) - 1;
        e.res = '0;
        e.ov  = 1'b0;
        e.c   = 1'b0;
        e.lat = 1;
        case (f)
            4'd0: begin
                p = ua + ub;
                e.res = 32'(p & m);
                e.c   = p[w];
                r = sa + sb;
                e.ov  = (r > hi) || (r < lo);
            end
            4'd1: begin
                e.res = 32'((ua - ub) & m);
                e.c   = (ua >= ub);
                r = sa - sb;
                e.ov  = (r > hi) || (r < lo);
            end
            4'd2: e.res = 32'(ua & ub);
            4'd3: e.res = 32'(ua | ub);
            4'd4: e.res = 32'(ua ^ ub);
            4'd5: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd8: begin
                p = ua * ub;
                e.res = 32'(p & m);
                e.ov  = ((p >> w) != 0);
                e.lat = w + 1;
            end
            4'd9: begin
                e.lat = w + 1;
                if (ub == 0) begin e.res = 32'(m); e.ov = 1'b1; end
                else e.res = 32'(ua / ub);
            end
            4'd10: begin
                e.lat = w + 1;
                if (ub == 0) begin e.res = 32'(ua); e.ov = 1'b1; end
                else e.res = 32'(ua % ub);
            end
            default: e.res = '0;
        endcase
        return e;
    endfunction

    // Performs one full transaction; lat counts cycles from accept to out_valid.
    task automatic run_op(input bit w8, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] f, output logic [31:0] r, output logic ov,
                          output logic c, output logic z, output logic n, output int lat);
        int guard;
        logic rdy, vld;
        r = '0; ov = 0; c = 0; z = 0; n = 0; lat = -1;
        @(negedge clk);
        guard = 0;
        rdy = w8 ? if8.in_ready : if32.in_ready;
        while (!rdy && guard < 200) begin
            @(negedge clk);
            guard++;
            rdy = w8 ? if8.in_ready : if32.in_ready;
        end
        if (!rdy) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        if (w8) begin
            if8.a = a[7:0]; if8.b = b[7:0]; if8.f = f; if8.in_valid = 1'b1;
        end else begin
            if32.a = a; if32.b = b; if32.f = f; if32.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        if8.in_valid  = 1'b0;
        if32.in_valid = 1'b0;
        lat = 0;
        vld = 1'b0;
        while (!vld && lat < 200) begin
            @(negedge clk);
            lat++;
            vld = w8 ? if8.out_valid : if32.out_valid;
        end
        if (!vld) begin
            check("out_valid_timeout", 0, 1);
            return;
        end
        if (w8) begin
            r = {24'd0, if8.result}; ov = if8.overflow; c = if8.carry;
            z = if8.zero; n = if8.negative;
            if8.out_ready = 1'b1;
        end else begin
            r = if32.result; ov = if32.overflow; c = if32.carry;
            z = if32.zero; n = if32.negative;
            if32.out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        if8.out_ready  = 1'b0;
        if32.out_ready = 1'b0;
    endtask

    vec_t vt[14];

    initial begin
        logic [31:0] r;
        logic ov, c, z, n;
        int lat;

        vt[0]  = '{0, 32'h7FFFFFFF, 32'h00000001, OP_ADD,  32'h80000000, 1, 0, 0, 1, 1};
        vt[1]  = '{0, 32'h00000005, 32'h00000005, OP_SUB,  32'h00000000, 0, 1, 1, 0, 1};
        vt[2]  = '{0, 32'hFFFFFFFF, 32'h00000001, OP_SLT,  32'h00000001, 0, 0, 0, 0, 1};
        vt[3]  = '{0, 32'h00010000, 32'h00010000, OP_MUL,  32'h00000000, 1, 0, 1, 0, 33};
        vt[4]  = '{0, 32'd7,        32'd6,        OP_MUL,  32'd42,       0, 0, 0, 0, 33};
        vt[5]  = '{1, 32'h7F,       32'h01,       OP_ADD,  32'h80,       1, 0, 0, 1, 1};
        vt[6]  = '{1, 32'h10,       32'h10,       OP_MUL,  32'h00,       1, 0, 1, 0, 9};
        vt[7]  = '{0, 32'd100,      32'd7,        OP_DIVU, 32'd14,       0, 0, 0, 0, 33};
        vt[8]  = '{0, 32'd100,      32'd7,        OP_REMU, 32'd2,        0, 0, 0, 0, 33};
        vt[9]  = '{0, 32'd9,        32'd0,        OP_DIVU, 32'hFFFFFFFF, 1, 0, 0, 1, 33};
        vt[10] = '{0, 32'd9,        32'd0,        OP_REMU, 32'd9,        1, 0, 0, 0, 33};
        vt[11] = '{0, 32'hF0F0F0F0, 32'hFF00FF00, OP_XOR,  32'h0FF00FF0, 0, 0, 0, 0, 1};
        vt[12] = '{0, 32'h12345678, 32'h9ABCDEF0, 4'b0111, 32'h00000000, 0, 0, 1, 0, 1};
        vt[13] = '{0, 32'h00000000, 32'h00000001, OP_SUB,  32'hFFFFFFFF, 0, 0, 0, 1, 1};

        if32.in_valid = 0; if32.out_ready = 0; if32.a = '0; if32.b = '0; if32.f = '0;
        if8.in_valid  = 0; if8.out_ready  = 0; if8.a  = '0; if8.b  = '0; if8.f  = '0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_in_ready32", if32.in_ready, 1);
        check("reset_out_valid32", if32.out_valid, 0);
        check("reset_result32", if32.result, 0);
        check("reset_flags32", {if32.zero, if32.overflow, if32.carry, if32.negative}, 0);
        check("reset_in_ready8", if8.in_ready, 1);
        check("reset_out_valid8", if8.out_valid, 0);
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].w8, vt[i].a, vt[i].b, vt[i].f, r, ov, c, z, n, lat);
            check($sformatf("vec%0d_result", i), r, vt[i].res);
            check($sformatf("vec%0d_overflow", i), ov, vt[i].ov);
            check($sformatf("vec%0d_carry", i), c, vt[i].c);
            check($sformatf("vec%0d_zero", i), z, vt[i].z);
            check($sformatf("vec%0d_negative", i), n, vt[i].n);
            check($sformatf("vec%0d_latency", i), lat, vt[i].lat);
        end

        // Reset in the middle of a mul: outputs clear without waiting for a clock edge
        @(negedge clk);
        if32.a = 32'd123; if32.b = 32'd456; if32.f = OP_MUL; if32.in_valid = 1'b1;
        @(posedge clk);
        #1 if32.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("midrun_out_valid_before", if32.out_valid, 0);
        check("midrun_result_before", if32.result, 32'hFFFFFFFF);
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_out_valid", if32.out_valid, 0);
        check("midrun_reset_result", if32.result, 0);
        check("midrun_reset_in_ready", if32.in_ready, 1);
        check("midrun_reset_negative", if32.negative, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("midrun_no_partial", if32.out_valid, 0);

        // Backpressure: result held, new op waits for the handshake
        @(negedge clk);
        if32.a = 32'd3; if32.b = 32'd4; if32.f = OP_ADD; if32.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if32.a = 32'd100; if32.b = 32'd200; if32.f = OP_ADD;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("bp_result_c%0d", k), if32.result, 32'd7);
            check($sformatf("bp_in_ready_c%0d", k), if32.in_ready, 0);
            check($sformatf("bp_out_valid_c%0d", k), if32.out_valid, 1);
        end
        if32.out_ready = 1'b1;
        @(posedge clk);
        #1 if32.out_ready = 1'b0;
        @(negedge clk);
        check("bp_after_hs_out_valid", if32.out_valid, 0);
        check("bp_after_hs_in_ready", if32.in_ready, 1);
        check("bp_after_hs_result_kept", if32.result, 32'd7);
        @(negedge clk);
        if32.in_valid = 1'b0;
        check("bp_new_out_valid", if32.out_valid, 1);
        check("bp_new_result", if32.result, 32'd300);
        if32.out_ready = 1'b1;
        @(posedge clk);
        #1 if32.out_ready = 1'b0;

        // Random operations against the reference model
        for (int i = 0; i < 300; i++) begin
            bit w8;
            logic [31:0] a, b;
            logic [3:0] f;
            exp_t e;
            int sel;
            logic [3:0] codes [12];
            codes = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd6, 4'd7, 4'd15};
            w8  = $urandom_range(0, 1);
            sel = $urandom_range(0, 11);
            f   = codes[sel];
            a   = $urandom;
            b   = $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'h0000000F;
            if ($urandom_range(0, 7) == 0) b = '0;
            if ($urandom_range(0, 7) == 0) a = b;
            if (w8) begin a = a & 32'hFF; b = b & 32'hFF; end
            e = model(w8 ? 8 : 32, a, b, f);
            run_op(w8, a, b, f, r, ov, c, z, n, lat);
            check($sformatf("rnd%0d_w%0d_f%0d_a%0h_b%0h_result", i, w8 ? 8 : 32, f, a, b), r, e.res);
            check($sformatf("rnd%0d_overflow", i), ov, e.ov);
            check($sformatf("rnd%0d_carry", i), c, e.c);
            check($sformatf("rnd%0d_zero", i), z, (e.res == 0));
            check($sformatf("rnd%0d_negative", i), n, w8 ? e.res[7] : e.res[31]);
            check($sformatf("rnd%0d_latency", i), lat, e.lat);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
